// File: rtl/key_event_queue.sv
// Keyboard scan-code event FIFO with sticky overflow and an interrupt FSM.
// Define KEYQ_BREAK_EN to queue break (F0) codes; by default they are dropped at the input.
//
// state    | meaning
// IDLE     | queue empty, irq low
// PEND     | events waiting for acknowledge, irq high
// SERVICED | acknowledged but queue still nonempty, irq low
module key_event_queue #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          code_valid,
  input  logic [23:0]   code,
  input  logic          rd_en,
  input  logic          reset_irq,
  input  logic          ovf_clr,
  output logic [15:0]   rdata,
  output logic          irq,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, PEND, SERVICED} state_t;

  state_t         state_q, state_d;
  logic [9:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]  count_next;
  logic [15:0]    rdata_next;
  logic [9:0]     entry;
  logic           is_break, valid_byte, brk_ok, ent_brk;
  logic           accept, full, push, pop, drop;

  assign is_break   = (code[15:8] == 8'hF0);
  assign valid_byte = (code[7:0] != 8'h00) && (code[7:0] != 8'hE0) && (code[7:0] != 8'hF0);

`ifdef KEYQ_BREAK_EN
  assign brk_ok  = 1'b1;
  assign ent_brk = is_break;
`else
  assign brk_ok  = !is_break;
  assign ent_brk = 1'b0;
`endif

  assign entry  = {ent_brk, (code[23:16] == 8'hE0), code[7:0]};
  assign accept = code_valid && valid_byte && brk_ok;
  assign full   = (count == CW'(DEPTH));
  assign pop    = rd_en && (count != '0);
  // A pop in the same cycle frees the slot, so a full queue still takes the push.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  assign count_next  = count + CW'(push) - CW'(pop);
  assign rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;

  // Head after this edge: the incoming entry bypasses memory when it becomes the sole entry.
  always_comb begin
    rdata_next = 16'h0000;
    if (count_next == '0)
      rdata_next = 16'h0000;
    else if (push && count_next == CW'(1))
      rdata_next = {1'b1, 5'b0, entry};
    else
      rdata_next = {1'b1, 5'b0, mem[rd_ptr_next]};
  end

  always_ff @(posedge CLOCK_50) begin
    if (push)
      mem[wr_ptr] <= entry;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rdata    <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      rdata  <= rdata_next;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (push)
          state_d = PEND;
      PEND:
        if (pop && count_next == '0 && !push)
          state_d = IDLE;
        else if (reset_irq && !push)
          state_d = SERVICED;
      SERVICED:
        if (push)
          state_d = PEND;
        else if (pop && count_next == '0)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    irq = (state_q == PEND);
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: a queue-based reference model predicts the
// post-edge outputs of every driven cycle; a monitor compares them after each rising edge.
module tb_key_event_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          code_valid = 1'b0;
  logic [23:0]   code = '0;
  logic          rd_en = 1'b0;
  logic          reset_irq = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [15:0]   rdata;
  logic          irq;
  logic [CW-1:0] count;
  logic          overflow;

  key_event_queue #(.DEPTH(DEPTH)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .code_valid(code_valid),
    .code      (code),
    .rd_en     (rd_en),
    .reset_irq (reset_irq),
    .ovf_clr   (ovf_clr),
    .rdata     (rdata),
    .irq       (irq),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [15:0] rdata;
    logic [31:0] count;
    logic        irq;
    logic        ovf;
  } snap_t;

  snap_t      exp_q[$];
  int         total = 0;
  int         bad = 0;

  // Reference model: plain queue of entries, irq mode (0 idle, 1 pending, 2 acknowledged), sticky flag.
  logic [9:0] mq[$];
  int         mst = 0;
  logic       movf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] model_head();
    if (mq.size() == 0) return 16'h0000;
    return {1'b1, 5'b0, mq[0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    mst  = 0;
    movf = 1'b0;
  endtask

  initial begin
    snap_t e;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_rdata", 32'(rdata), 32'(e.rdata));
        chk("sb_count", 32'(count), e.count);
        chk("sb_irq", 32'(irq), 32'(e.irq));
        chk("sb_overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  // Drive one cycle at the falling edge, predict its result, then idle the strobes after the edge.
  task automatic step(input logic cv, input logic [23:0] cd, input logic rd,
                      input logic ri, input logic oc);
    logic  acc, brk, can_pop, pushed, drop;
    int    n0;
    snap_t s;
    @(negedge CLOCK_50);
    code_valid = cv; code = cd; rd_en = rd; reset_irq = ri; ovf_clr = oc;
    brk = (cd[15:8] == 8'hF0);
    acc = cv && !(cd[7:0] inside {8'h00, 8'hE0, 8'hF0});
`ifndef KEYQ_BREAK_EN
    if (brk) acc = 1'b0;
    brk = 1'b0;
`endif
    n0      = mq.size();
    can_pop = rd && (n0 > 0);
    pushed  = acc && ((n0 < DEPTH) || can_pop);
    drop    = acc && (n0 == DEPTH) && !can_pop;
    if (can_pop) void'(mq.pop_front());
    if (pushed) mq.push_back({brk, cd[23:16] == 8'hE0, cd[7:0]});
    if (drop) movf = 1'b1;
    else if (oc) movf = 1'b0;
    if (mst == 0 && pushed) mst = 1;
    else if (mst != 0 && can_pop && mq.size() == 0 && !pushed) mst = 0;
    else if (mst == 1 && ri && !pushed) mst = 2;
    else if (mst == 2 && pushed) mst = 1;
    s.rdata = model_head();
    s.count = mq.size();
    s.irq   = (mst == 1);
    s.ovf   = movf;
    exp_q.push_back(s);
    @(posedge CLOCK_50);
    #2;
    code_valid = 1'b0; code = '0; rd_en = 1'b0; reset_irq = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic drain();
    while (mq.size() > 0) step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [23:0] rand_code();
    logic [7:0] pe, pf, cb;
    int         k;
    pe = ($urandom_range(0, 1) == 1) ? 8'hE0 : 8'h00;
    k  = $urandom_range(0, 9);
    pf = (k < 3) ? 8'hF0 : ((k == 3) ? 8'($urandom) : 8'h00);
    k  = $urandom_range(0, 7);
    if (k == 0) cb = 8'h00;
    else if (k == 1) cb = 8'hE0;
    else if (k == 2) cb = 8'hF0;
    else cb = 8'($urandom);
    return {pe, pf, cb};
  endfunction

  initial begin
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    @(negedge CLOCK_50);
    reset = 1'b1;

    step(1'b1, 24'h00001C, 1'b0, 1'b0, 1'b0);
    chk("make_rdata", 32'(rdata), 32'h801C);
    chk("make_count", 32'(count), 32'h1);
    chk("make_irq", 32'(irq), 32'h1);
    drain();

    step(1'b1, 24'hE00075, 1'b0, 1'b0, 1'b0);
    chk("ext_rdata", 32'(rdata), 32'h8175);
    step(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    chk("ack_irq", 32'(irq), 32'h0);
    chk("ack_rdata", 32'(rdata), 32'h8175);
    step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    chk("ext_pop_rdata", 32'(rdata), 32'h0);
    chk("ext_pop_count", 32'(count), 32'h0);
    step(1'b1, 24'h000016, 1'b0, 1'b0, 1'b0);
    chk("idle_repend_irq", 32'(irq), 32'h1);
    drain();

    for (int i = 1; i <= DEPTH + 1; i++) step(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_head", 32'(rdata), 32'h8001);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("ovf_order", 32'(rdata), 32'h8000 + 32'(i));
      step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf_empty", 32'(rdata), 32'h0);
    step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    chk("empty_pop_count", 32'(count), 32'h0);
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'h0);

    for (int i = 0; i < DEPTH; i++) step(1'b1, 24'h10 + 24'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h00002A, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", 32'(count), 32'(DEPTH));
    chk("fullpp_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    chk("fullpp_last", 32'(rdata), 32'h802A);
    drain();

    step(1'b1, 24'h00F01C, 1'b0, 1'b0, 1'b0);
`ifdef KEYQ_BREAK_EN
    chk("break_rdata", 32'(rdata), 32'h821C);
    chk("break_irq", 32'(irq), 32'h1);
`else
    chk("break_count", 32'(count), 32'h0);
    chk("break_irq", 32'(irq), 32'h0);
`endif
    drain();

    for (int i = 0; i < 3; i++) step(1'b1, 24'h40 + 24'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'h3);
    chk("pre_reset_irq", 32'(irq), 32'h1);
    reset = 1'b0;
    #1;
    chk("async_reset_count", 32'(count), 32'h0);
    chk("async_reset_irq", 32'(irq), 32'h0);
    chk("async_reset_rdata", 32'(rdata), 32'h0);
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
    step(1'b1, 24'h000033, 1'b0, 1'b0, 1'b0);
    chk("post_reset_rdata", 32'(rdata), 32'h8033);
    chk("post_reset_irq", 32'(irq), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      int phase;
      logic rd;
      phase = (i / 150) % 3;
      if (phase == 0) rd = ($urandom_range(0, 5) == 0);
      else if (phase == 1) rd = ($urandom_range(0, 1) == 0);
      else rd = ($urandom_range(0, 5) != 0);
      step(1'($urandom_range(0, 1)), rand_code(), rd,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    @(posedge CLOCK_50);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEPTH, 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter CW, $clog2(DEPTH)+1, count width; derived, not overridden.
REQ-003 CLOCK_50  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 code_valid  in  1  one-cycle strobe: complete scan code present on code.
REQ-006 code  in  24  {E0 prefix byte, F0 prefix byte, code byte}; prefix bytes are 00 when absent.
REQ-007 rd_en  in  1  CPU read strobe; pops head entry.
REQ-008 reset_irq  in  1  CPU interrupt acknowledge strobe.
REQ-009 ovf_clr  in  1  clears sticky overflow.
REQ-010 rdata  out  16  head entry, registered: [15] nonempty, [9] break, [8] extended, [7:0] code, others 0.
REQ-011 irq  out  1  interrupt request, registered.
REQ-012 count  out  CW  current occupancy, 0..DEPTH.
REQ-013 overflow  out  1  sticky: at least one event dropped since the last clear.

Function
REQ-014 Entry encoding: extended = (code[23:16]==8'hE0); break = (code[15:8]==8'hF0); code byte = code[7:0].
REQ-015 Push on code_valid when accepted (see REQ-024); entry visible on rdata the cycle after the push edge if the FIFO was empty.
REQ-016 rdata always reflects the current head, one cycle after any push/pop; rdata = 16'h0000 when empty.
REQ-017 Pop on rd_en when count>0; the next entry appears on rdata the following cycle.
REQ-018 rd_en while empty is ignored: no state change, no error.
REQ-019 Push with count==DEPTH and no same-cycle pop: entry dropped, overflow set to 1, count unchanged.
REQ-020 Simultaneous push and pop while full: both succeed, count stays DEPTH, overflow not set.
REQ-021 Simultaneous push and pop while empty: push only; rd_en ignored.
REQ-022 Read/write pointers wrap modulo DEPTH; count = pushes - pops, never exceeds DEPTH.
REQ-023 overflow clears on ovf_clr; a same-cycle overflow event wins (overflow stays 1).
REQ-024 Accepted codes: code[7:0] not 00, not E0, not F0; other strobes ignored with no side effect.
REQ-025 IRQ FSM states: IDLE (irq=0, queue empty), PEND (irq=1), SERVICED (irq=0, queue nonempty).
REQ-026 IDLE -> PEND on accepted push.
REQ-027 PEND -> SERVICED on reset_irq without a same-cycle accepted push; reset_irq with push stays PEND.
REQ-028 SERVICED -> PEND on accepted push.
REQ-029 PEND or SERVICED -> IDLE when a pop leaves count==0 with no same-cycle push.
REQ-030 irq equals (state==PEND), registered, with one cycle latency from the triggering edge.
REQ-031 reset_irq in IDLE or SERVICED has no effect.

Reset
REQ-032 reset low asynchronously clears pointers and count to 0, rdata to 16'h0000, irq to 0, overflow to 0, FSM to IDLE.
REQ-033 Reset during a pending push/pop discards it; FIFO contents need not be cleared.
REQ-034 First push is accepted on the first rising edge after reset deasserts.

Configuration
REQ-035 Macro KEYQ_BREAK_EN: when defined, break codes are queued with rdata[9]=1 and trigger IDLE/SERVICED -> PEND like make codes.
REQ-036 Without KEYQ_BREAK_EN: break codes are dropped at the input (no push, no overflow, no FSM effect), and rdata[9] is always 0.

Verification
REQ-037 Reset, then code_valid with code=24'h00001C -> next cycle rdata=16'h801C, count=1, irq=1.
REQ-038 code=24'hE00075, then reset_irq, then rd_en -> rdata=16'h8175; irq=0 after the ack; after the pop rdata=0, count=0, FSM IDLE.
REQ-039 Push DEPTH+1 codes 01..09 (DEPTH=8) -> count=8, overflow=1, rdata shows 01; 8 pops read 01..08 in order; ovf_clr -> overflow=0.
REQ-040 Full FIFO plus same-cycle push 0x2A and rd_en -> count stays 8, overflow=0, 0x2A is read last.
REQ-041 code=24'h00F01C: with KEYQ_BREAK_EN -> rdata=16'h821C, irq=1; without KEYQ_BREAK_EN -> count=0, irq=0.
REQ-042 Assert reset mid-stream with count=3 and irq=1 -> immediately count=0, irq=0, rdata=0; push after release -> normal operation.
